// File: rtl/imu_i2c_responder.sv
// imu_i2c_responder: I2C target emulating a six-axis IMU register map.
// Ports: clk, rst_n; scl in, sda open-drain inout; sample_valid with
//   accel_*/gyro_* sample load; cfg_* register mirrors; wr_strobe and
//   wr_addr for bus writes; busy while addressed.
// Build option: define IMU_AUTOINC_EN to auto-increment the pointer.
`timescale 1ns/1ps
module imu_i2c_responder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl,
   inout  wire         sda,
   input  logic        sample_valid,
   input  logic [15:0] accel_x,
   input  logic [15:0] accel_y,
   input  logic [15:0] accel_z,
   input  logic [15:0] gyro_x,
   input  logic [15:0] gyro_y,
   input  logic [15:0] gyro_z,
   output logic [7:0]  cfg_pwr,
   output logic [7:0]  cfg_smplrt,
   output logic [7:0]  cfg_dlpf,
   output logic [7:0]  cfg_gyro,
   output logic [7:0]  cfg_accel,
   output logic        wr_strobe,
   output logic [7:0]  wr_addr,
   output logic        busy
);
   localparam logic [6:0] DEV_ADDR     = 7'h68;
   localparam logic [7:0] WHO_AM_I_VAL = 8'h68;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t      state, state_n;
   logic [1:0]  scl_sync, sda_sync;
   logic        scl_d, sda_d, scl_s, sda_s;
   logic        scl_rise, scl_fall, start_ev, stop_ev;
   logic [3:0]  bit_cnt;
   logic        bit_done, addr_hit;
   logic [7:0]  rx_sr, ptr, ptr_step, rd_byte;
   logic [6:0]  tx_sr;
   logic        rw_q, m_ack, sda_oe;
   logic [95:0] pend, shadow;
   logic        pend_v;

   assign sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign scl_s    = scl_sync[1];
   assign sda_s    = sda_sync[1];
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
   assign bit_done = (bit_cnt == 4'd8);
   assign addr_hit = (rx_sr[7:1] == DEV_ADDR);

`ifdef IMU_AUTOINC_EN
   assign ptr_step = ptr + 8'd1;
`else
   assign ptr_step = ptr;
`endif

   // shadow packs {ax, ay, az, gx, gy, gz}, high byte first
   always_comb begin
      rd_byte = 8'h00;
      case (ptr)
         8'h19:   rd_byte = cfg_smplrt;
         8'h1A:   rd_byte = cfg_dlpf;
         8'h1B:   rd_byte = cfg_gyro;
         8'h1C:   rd_byte = cfg_accel;
         8'h6B:   rd_byte = cfg_pwr;
         8'h3B:   rd_byte = shadow[95:88];
         8'h3C:   rd_byte = shadow[87:80];
         8'h3D:   rd_byte = shadow[79:72];
         8'h3E:   rd_byte = shadow[71:64];
         8'h3F:   rd_byte = shadow[63:56];
         8'h40:   rd_byte = shadow[55:48];
         8'h43:   rd_byte = shadow[47:40];
         8'h44:   rd_byte = shadow[39:32];
         8'h45:   rd_byte = shadow[31:24];
         8'h46:   rd_byte = shadow[23:16];
         8'h47:   rd_byte = shadow[15:8];
         8'h48:   rd_byte = shadow[7:0];
         8'h75:   rd_byte = WHO_AM_I_VAL;
         default: rd_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_n = state;
      if (stop_ev) begin
         state_n = IDLE;
      end else if (start_ev) begin
         state_n = ADDR;
      end else if (scl_fall) begin
         case (state)
            ADDR:
               if (bit_done)
                  state_n = addr_hit ? ADDR_ACK : IGNORE;
            ADDR_ACK:  state_n = rw_q ? RDATA : REG;
            REG:       if (bit_done) state_n = REG_ACK;
            REG_ACK:   state_n = WDATA;
            WDATA:     if (bit_done) state_n = WDATA_ACK;
            WDATA_ACK: state_n = WDATA;
            RDATA:     if (bit_done) state_n = RDATA_ACK;
            RDATA_ACK: state_n = m_ack ? RDATA : IGNORE;
            default:   state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // pending copy waits for IDLE so a burst never mixes two samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend   <= '0;
         pend_v <= 1'b0;
         shadow <= '0;
      end else begin
         if (sample_valid) begin
            pend   <= {accel_x, accel_y, accel_z,
                       gyro_x, gyro_y, gyro_z};
            pend_v <= 1'b1;
         end else if (state == IDLE) begin
            pend_v <= 1'b0;
         end
         if (pend_v && state == IDLE) shadow <= pend;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         bit_cnt    <= 4'd0;
         rx_sr      <= 8'h00;
         tx_sr      <= 7'h00;
         ptr        <= 8'h00;
         rw_q       <= 1'b0;
         m_ack      <= 1'b0;
         wr_strobe  <= 1'b0;
         wr_addr    <= 8'h00;
         cfg_pwr    <= 8'h40;
         cfg_smplrt <= 8'h00;
         cfg_dlpf   <= 8'h00;
         cfg_gyro   <= 8'h00;
         cfg_accel  <= 8'h00;
      end else begin
         wr_strobe <= 1'b0;
         if (stop_ev) begin
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
         end else if (start_ev) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
         end else if (scl_rise) begin
            case (state)
               ADDR, REG, WDATA: begin
                  rx_sr   <= {rx_sr[6:0], sda_s};
                  bit_cnt <= bit_cnt + 4'd1;
               end
               RDATA:     bit_cnt <= bit_cnt + 4'd1;
               RDATA_ACK: m_ack <= ~sda_s;
               WDATA_ACK: begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  ptr       <= ptr_step;
                  case (ptr)
                     8'h19:   cfg_smplrt <= rx_sr;
                     8'h1A:   cfg_dlpf   <= rx_sr;
                     8'h1B:   cfg_gyro   <= rx_sr;
                     8'h1C:   cfg_accel  <= rx_sr;
                     8'h6B:   cfg_pwr    <= rx_sr;
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ADDR:
                  if (bit_done) begin
                     bit_cnt <= 4'd0;
                     if (addr_hit) begin
                        sda_oe <= 1'b1;
                        busy   <= 1'b1;
                        rw_q   <= rx_sr[0];
                     end
                  end
               ADDR_ACK: begin
                  sda_oe <= rw_q ? ~rd_byte[7] : 1'b0;
                  tx_sr  <= rd_byte[6:0];
               end
               REG:
                  if (bit_done) begin
                     ptr     <= rx_sr;
                     sda_oe  <= 1'b1;
                     bit_cnt <= 4'd0;
                  end
               WDATA:
                  if (bit_done) begin
                     sda_oe  <= 1'b1;
                     bit_cnt <= 4'd0;
                  end
               REG_ACK, WDATA_ACK: sda_oe <= 1'b0;
               RDATA:
                  if (bit_done) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     ptr     <= ptr_step;
                  end else begin
                     tx_sr  <= {tx_sr[5:0], 1'b0};
                     sda_oe <= ~tx_sr[6];
                  end
               RDATA_ACK: begin
                  tx_sr  <= rd_byte[6:0];
                  sda_oe <= m_ack & ~rd_byte[7];
               end
               default: ;
            endcase
         end
      end
   end
endmodule
